// File: rtl/gate_vector_sequencer.sv
// Clocked stimulus/capture sequencer for the 3-input basic-gate block.
// Steps {a,b,c} through 000..111, holding each for DWELL cycles and recording y per vector.
module gate_vector_sequencer #(
   parameter int unsigned DWELL = 10,
   parameter int unsigned NUM_Y = 7,
   parameter bit          LOOP  = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NUM_Y-1:0]     y,
   output logic                 a,
   output logic                 b,
   output logic                 c,
   output logic [2:0]           vec_idx,
   output logic                 vec_valid,
   output logic [8*NUM_Y-1:0]   capture,
   output logic                 busy,
   output logic                 done
);

   localparam int unsigned      CNT_W  = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       vec_d;
   logic             busy_d, done_d;
   logic             cap_we, cap_clr;

   // Next-state, counter and capture control
   always_comb begin
      state_d = state_q;
      vec_d   = vec_idx;
      cnt_d   = cnt_q;
      cap_we  = 1'b0;
      cap_clr = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               state_d = RUN;
               vec_d   = 3'd0;
               cnt_d   = RELOAD;
               cap_clr = 1'b1;
            end
         end
         RUN: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               cap_we = 1'b1;
               if (vec_idx == 3'd7 && !LOOP) begin
                  state_d = DONE;
               end else begin
                  vec_d = vec_idx + 3'd1;
                  cnt_d = RELOAD;
               end
            end
            // abort still lets a same-edge sample land, then drops to IDLE
            if (abort) begin
               state_d = IDLE;
               vec_d   = 3'd0;
               cnt_d   = '0;
            end
         end
         DONE: begin
            state_d = IDLE;
            vec_d   = 3'd0;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            vec_d   = 3'd0;
            cnt_d   = '0;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State, index, status and response-table registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         vec_idx <= 3'd0;
         cnt_q   <= '0;
         capture <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_idx <= vec_d;
         cnt_q   <= cnt_d;
         busy    <= busy_d;
         done    <= done_d;
         if (cap_clr) begin
            capture <= '0;
         end else if (cap_we) begin
            for (int i = 0; i < 8; i++) begin
               if (vec_idx == 3'(i)) capture[i*NUM_Y +: NUM_Y] <= y;
            end
         end
      end
   end

   assign {a, b, c} = vec_idx;
   assign vec_valid = (state_q == RUN) && (cnt_q == '0);

endmodule
